// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hard-wired control unit: FSM states, branch
// condition codes, ALU operation codes and instruction opcodes.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_IDLE = 4'd1,
        ST_T0   = 4'd2,
        ST_T1   = 4'd3,
        ST_T2   = 4'd4,
        ST_T3   = 4'd5,
        ST_T4   = 4'd6,
        ST_T5   = 4'd7,
        ST_T6   = 4'd8
    } state_e;

    // C2 field of a branch instruction
    localparam logic [1:0] COND_ZR = 2'b00;
    localparam logic [1:0] COND_NZ = 2'b01;
    localparam logic [1:0] COND_PL = 2'b10;
    localparam logic [1:0] COND_MI = 2'b11;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    localparam logic [4:0] OP_BRANCH = 5'b10010;

endpackage : cpu_ctrl_pkg

// File: rtl/con_ff_eval.sv
// Branch-condition decode and the CON flip-flop. The flop captures the
// decoded condition of the Ra value on the bus whenever CON_in is high.
module con_ff_eval
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  CON_in,
    input  logic [1:0]            c2,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic                  con
);

    logic con_q;
    logic con_d;
    logic cond_hit;
    logic bus_zero;
    logic bus_neg;

    assign bus_zero = (bus_in == '0);
    assign bus_neg  = bus_in[DATA_WIDTH-1];

    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        cond_hit = 1'b0;
        case (c2)
            COND_ZR: cond_hit = bus_zero;
            COND_NZ: cond_hit = !bus_zero;
            COND_PL: cond_hit = !bus_neg && !bus_zero;
            COND_MI: cond_hit = bus_neg;
            default: cond_hit = 1'b0;
        endcase
    end

    always_comb begin
        con_d = con_q;
        if (CON_in) begin
            con_d = cond_hit;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples values from before the edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            con_q <= 1'b0;
        end else begin
            con_q <= con_d;
        end
    end

    assign con = con_q;

endmodule : con_ff_eval

// File: rtl/branch_step_sequencer.sv
// Hard-wired control-step sequencer for the branch class (brzr/brnz/brpl/brmi):
// fetch in T0-T2, branch steps in T3-T6, with memory wait and illegal-op trap.
module branch_step_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  OPCODE_W       = 5,
    parameter logic [OPCODE_W-1:0] BR_OPCODE      = OP_BRANCH,
    parameter int                  C2_LSB         = 19,
    parameter logic [4:0]          ADD_OP         = ALU_ADD,
    parameter bit                  FAST_NOT_TAKEN = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] ir_in,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  PCin,
    output logic                  Read,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Gra,
    output logic                  Rout,
    output logic                  CON_in,
    output logic                  Yin,
    output logic                  Cout,
    output logic [4:0]            alu_op,
    output logic                  con,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal_op
);

    state_e state_q;
    state_e state_d;
    logic   is_branch;
    logic   unused_ir;

    assign is_branch = (ir_in[DATA_WIDTH-1 -: OPCODE_W] == BR_OPCODE);
    assign unused_ir = ^ir_in;

    con_ff_eval #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_con_ff_eval (
        .Clock (Clock),
        .Reset (Reset),
        .CON_in(CON_in),
        .c2    (ir_in[C2_LSB+1:C2_LSB]),
        .bus_in(bus_in),
        .con   (con)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Gra        = 1'b0;
        Rout       = 1'b0;
        CON_in     = 1'b0;
        Yin        = 1'b0;
        Cout       = 1'b0;
        alu_op     = ALU_NOP;
        done       = 1'b0;
        illegal_op = 1'b0;
        busy       = (state_q != ST_RST) && (state_q != ST_IDLE);

        case (state_q)
            ST_RST: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_T0;
                end
            end
            ST_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                // Reloading PC from an unchanged Z while waiting is harmless.
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                if (!is_branch) begin
                    illegal_op = 1'b1;
                    state_d    = run ? ST_T0 : ST_IDLE;
                end else begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    CON_in  = 1'b1;
                    state_d = ST_T4;
                end
            end
            ST_T4: begin
                if (FAST_NOT_TAKEN && !con) begin
                    done    = 1'b1;
                    state_d = run ? ST_T0 : ST_IDLE;
                end else begin
                    PCout   = 1'b1;
                    Yin     = 1'b1;
                    state_d = ST_T5;
                end
            end
            ST_T5: begin
                Cout    = 1'b1;
                Zin     = 1'b1;
                alu_op  = ADD_OP;
                state_d = ST_T6;
            end
            ST_T6: begin
                Zlowout = con;
                PCin    = con;
                done    = 1'b1;
                state_d = run ? ST_T0 : ST_IDLE;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

endmodule : branch_step_sequencer

// File: tb/tb_branch_step_sequencer.sv
// Directed, table-driven bench for branch_step_sequencer. Two instances share
// stimulus: u_fast (FAST_NOT_TAKEN=1) and u_slow (FAST_NOT_TAKEN=0).
module tb_branch_step_sequencer;

    typedef struct packed {
        logic       PCout;
        logic       MARin;
        logic       IncPC;
        logic       Zin;
        logic       Zlowout;
        logic       PCin;
        logic       Read;
        logic       MDRin;
        logic       MDRout;
        logic       IRin;
        logic       Gra;
        logic       Rout;
        logic       CON_in;
        logic       Yin;
        logic       Cout;
        logic [4:0] alu_op;
        logic       con;
        logic       busy;
        logic       done;
        logic       illegal_op;
    } obs_t;

    typedef struct {
        string       name;
        logic        run;
        logic        mem_ready;
        logic [31:0] ir;
        logic [31:0] bus;
        obs_t        exp;
        logic        sel_slow;
    } vec_t;

    localparam obs_t E_IDLE  = '0;
    localparam obs_t E_T0    = '{PCout: 1'b1, MARin: 1'b1, IncPC: 1'b1, Zin: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T1    = '{Zlowout: 1'b1, PCin: 1'b1, Read: 1'b1, MDRin: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T2    = '{MDRout: 1'b1, IRin: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T3    = '{Gra: 1'b1, Rout: 1'b1, CON_in: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T3ILL = '{illegal_op: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T4    = '{PCout: 1'b1, Yin: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T4EX  = '{done: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T5    = '{Cout: 1'b1, Zin: 1'b1, alu_op: 5'd3, busy: 1'b1, default: '0};
    localparam obs_t E_T6TK  = '{Zlowout: 1'b1, PCin: 1'b1, done: 1'b1, busy: 1'b1, default: '0};
    localparam obs_t E_T6NT  = '{done: 1'b1, busy: 1'b1, default: '0};

    localparam logic [31:0] I_BRZR = 32'h9280_0023;
    localparam logic [31:0] I_BRNZ = 32'h9288_0023;
    localparam logic [31:0] I_BRPL = 32'h9290_0023;
    localparam logic [31:0] I_BRMI = 32'h9298_0023;
    localparam logic [31:0] I_ILL  = 32'h1800_0000;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir_in;
    logic [31:0] bus_in;

    logic pcout_f, marin_f, incpc_f, zin_f, zlowout_f, pcin_f, read_f, mdrin_f;
    logic mdrout_f, irin_f, gra_f, rout_f, conin_f, yin_f, cout_f;
    logic con_f, busy_f, done_f, ill_f;
    logic [4:0] aluop_f;
    logic pcout_s, marin_s, incpc_s, zin_s, zlowout_s, pcin_s, read_s, mdrin_s;
    logic mdrout_s, irin_s, gra_s, rout_s, conin_s, yin_s, cout_s;
    logic con_s, busy_s, done_s, ill_s;
    logic [4:0] aluop_s;

    obs_t obs_f;
    obs_t obs_s;

    assign obs_f = {pcout_f, marin_f, incpc_f, zin_f, zlowout_f, pcin_f, read_f, mdrin_f,
                    mdrout_f, irin_f, gra_f, rout_f, conin_f, yin_f, cout_f,
                    aluop_f, con_f, busy_f, done_f, ill_f};
    assign obs_s = {pcout_s, marin_s, incpc_s, zin_s, zlowout_s, pcin_s, read_s, mdrin_s,
                    mdrout_s, irin_s, gra_s, rout_s, conin_s, yin_s, cout_s,
                    aluop_s, con_s, busy_s, done_s, ill_s};

    branch_step_sequencer #(.FAST_NOT_TAKEN(1'b1)) u_fast (
        .Clock(Clock), .Reset(Reset), .run(run), .mem_ready(mem_ready),
        .ir_in(ir_in), .bus_in(bus_in),
        .PCout(pcout_f), .MARin(marin_f), .IncPC(incpc_f), .Zin(zin_f),
        .Zlowout(zlowout_f), .PCin(pcin_f), .Read(read_f), .MDRin(mdrin_f),
        .MDRout(mdrout_f), .IRin(irin_f), .Gra(gra_f), .Rout(rout_f),
        .CON_in(conin_f), .Yin(yin_f), .Cout(cout_f), .alu_op(aluop_f),
        .con(con_f), .busy(busy_f), .done(done_f), .illegal_op(ill_f)
    );

    branch_step_sequencer #(.FAST_NOT_TAKEN(1'b0)) u_slow (
        .Clock(Clock), .Reset(Reset), .run(run), .mem_ready(mem_ready),
        .ir_in(ir_in), .bus_in(bus_in),
        .PCout(pcout_s), .MARin(marin_s), .IncPC(incpc_s), .Zin(zin_s),
        .Zlowout(zlowout_s), .PCin(pcin_s), .Read(read_s), .MDRin(mdrin_s),
        .MDRout(mdrout_s), .IRin(irin_s), .Gra(gra_s), .Rout(rout_s),
        .CON_in(conin_s), .Yin(yin_s), .Cout(cout_s), .alu_op(aluop_s),
        .con(con_s), .busy(busy_s), .done(done_s), .illegal_op(ill_s)
    );

    always #5 Clock = ~Clock;

    int   tests_run = 0;
    int   failures  = 0;
    vec_t vecs[$];

    task automatic check(input string nm, input obs_t act, input obs_t exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then sample.
    task automatic cycle(input string nm, input logic r, input logic mr,
                         input logic [31:0] ir, input logic [31:0] bus,
                         input obs_t base, input logic c, input logic sel_slow);
        obs_t exp;
        @(negedge Clock);
        run       = r;
        mem_ready = mr;
        ir_in     = ir;
        bus_in    = bus;
        #1;
        exp     = base;
        exp.con = c;
        check(nm, sel_slow ? obs_s : obs_f, exp);
    endtask

    task automatic add(input string nm, input logic r, input logic mr,
                       input logic [31:0] ir, input logic [31:0] bus,
                       input obs_t base, input logic c, input logic sel_slow);
        vec_t v;
        v.name      = nm;
        v.run       = r;
        v.mem_ready = mr;
        v.ir        = ir;
        v.bus       = bus;
        v.exp       = base;
        v.exp.con   = c;
        v.sel_slow  = sel_slow;
        vecs.push_back(v);
    endtask

    task automatic play();
        foreach (vecs[i]) begin
            cycle(vecs[i].name, vecs[i].run, vecs[i].mem_ready, vecs[i].ir,
                  vecs[i].bus, vecs[i].exp, vecs[i].exp.con, vecs[i].sel_slow);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        run   = 1'b0;
        #1;
        check("reset_fast", obs_f, E_IDLE);
        check("reset_slow", obs_s, E_IDLE);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b1;
        ir_in     = '0;
        bus_in    = '0;

        // Fast instance: taken/not-taken branches and condition boundaries.
        do_reset();
        add("zr_idle", 1, 1, I_BRZR, 32'h0, E_IDLE, 0, 0);
        add("zr_t0",   1, 1, I_BRZR, 32'h0, E_T0,   0, 0);
        add("zr_t1",   1, 1, I_BRZR, 32'h0, E_T1,   0, 0);
        add("zr_t2",   1, 1, I_BRZR, 32'h0, E_T2,   0, 0);
        add("zr_t3",   1, 1, I_BRZR, 32'h0, E_T3,   0, 0);
        add("zr_t4",   1, 1, I_BRZR, 32'h0, E_T4,   1, 0);
        add("zr_t5",   1, 1, I_BRZR, 32'h0, E_T5,   1, 0);
        add("zr_t6",   1, 1, I_BRZR, 32'h0, E_T6TK, 1, 0);
        add("zrn_t0",  1, 1, I_BRZR, 32'h5, E_T0,   1, 0);
        add("zrn_t1",  1, 1, I_BRZR, 32'h5, E_T1,   1, 0);
        add("zrn_t2",  1, 1, I_BRZR, 32'h5, E_T2,   1, 0);
        add("zrn_t3",  1, 1, I_BRZR, 32'h5, E_T3,   1, 0);
        add("zrn_t4",  1, 1, I_BRZR, 32'h5, E_T4EX, 0, 0);
        add("mi_t0",   1, 1, I_BRMI, 32'h8000_0000, E_T0,   0, 0);
        add("mi_t1",   1, 1, I_BRMI, 32'h8000_0000, E_T1,   0, 0);
        add("mi_t2",   1, 1, I_BRMI, 32'h8000_0000, E_T2,   0, 0);
        add("mi_t3",   1, 1, I_BRMI, 32'h8000_0000, E_T3,   0, 0);
        add("mi_t4",   1, 1, I_BRMI, 32'h8000_0000, E_T4,   1, 0);
        add("mi_t5",   1, 1, I_BRMI, 32'h8000_0000, E_T5,   1, 0);
        add("mi_t6",   1, 1, I_BRMI, 32'h8000_0000, E_T6TK, 1, 0);
        add("pl0_t0",  1, 1, I_BRPL, 32'h0, E_T0,   1, 0);
        add("pl0_t1",  1, 1, I_BRPL, 32'h0, E_T1,   1, 0);
        add("pl0_t2",  1, 1, I_BRPL, 32'h0, E_T2,   1, 0);
        add("pl0_t3",  1, 1, I_BRPL, 32'h0, E_T3,   1, 0);
        add("pl0_t4",  1, 1, I_BRPL, 32'h0, E_T4EX, 0, 0);
        add("plmax_t0", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T0,   0, 0);
        add("plmax_t1", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T1,   0, 0);
        add("plmax_t2", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T2,   0, 0);
        add("plmax_t3", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T3,   0, 0);
        add("plmax_t4", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T4,   1, 0);
        add("plmax_t5", 1, 1, I_BRPL, 32'h7FFF_FFFF, E_T5,   1, 0);
        add("plmax_t6", 0, 1, I_BRPL, 32'h7FFF_FFFF, E_T6TK, 1, 0);
        add("hold_idle0", 0, 1, I_BRPL, 32'h0, E_IDLE, 1, 0);
        add("hold_idle1", 0, 1, I_BRPL, 32'h0, E_IDLE, 1, 0);
        play();

        // Slow instance: brnz not taken runs the full T5/T6 sequence.
        do_reset();
        add("nz_idle", 1, 1, I_BRNZ, 32'h0, E_IDLE, 0, 1);
        add("nz_t0",   1, 1, I_BRNZ, 32'h0, E_T0,   0, 1);
        add("nz_t1",   1, 1, I_BRNZ, 32'h0, E_T1,   0, 1);
        add("nz_t2",   1, 1, I_BRNZ, 32'h0, E_T2,   0, 1);
        add("nz_t3",   1, 1, I_BRNZ, 32'h0, E_T3,   0, 1);
        add("nz_t4",   1, 1, I_BRNZ, 32'h0, E_T4,   0, 1);
        add("nz_t5",   1, 1, I_BRNZ, 32'h0, E_T5,   0, 1);
        add("nz_t6",   0, 1, I_BRNZ, 32'h0, E_T6NT, 0, 1);
        add("nz_idle2", 0, 1, I_BRNZ, 32'h0, E_IDLE, 0, 1);
        play();

        // Memory wait in T1, then an illegal opcode trapped in T3.
        do_reset();
        cycle("mw_idle", 1, 1, I_ILL, 32'h0, E_IDLE, 0, 0);
        cycle("mw_t0",   1, 1, I_ILL, 32'h0, E_T0,   0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("mw_t1_wait", 1, 0, I_ILL, 32'h0, E_T1, 0, 0);
        end
        cycle("mw_t1_ready", 1, 1, I_ILL, 32'h0, E_T1,    0, 0);
        cycle("mw_t2",       1, 1, I_ILL, 32'h0, E_T2,    0, 0);
        cycle("ill_t3",      1, 1, I_ILL, 32'h0, E_T3ILL, 0, 0);
        cycle("ill_next_t0", 1, 1, I_ILL, 32'h0, E_T0,    0, 0);

        // Reset asserted in T5 of a taken branch, released with run low.
        do_reset();
        cycle("ro_idle", 1, 1, I_BRZR, 32'h0, E_IDLE, 0, 0);
        cycle("ro_t0",   1, 1, I_BRZR, 32'h0, E_T0,   0, 0);
        cycle("ro_t1",   1, 1, I_BRZR, 32'h0, E_T1,   0, 0);
        cycle("ro_t2",   1, 1, I_BRZR, 32'h0, E_T2,   0, 0);
        cycle("ro_t3",   1, 1, I_BRZR, 32'h0, E_T3,   0, 0);
        cycle("ro_t4",   1, 1, I_BRZR, 32'h0, E_T4,   1, 0);
        cycle("ro_t5",   1, 1, I_BRZR, 32'h0, E_T5,   1, 0);
        #2;
        Reset = 1'b1;
        #1;
        check("ro_async_fast", obs_f, E_IDLE);
        check("ro_async_slow", obs_s, E_IDLE);
        @(negedge Clock);
        #1;
        check("ro_held", obs_f, E_IDLE);
        run   = 1'b0;
        Reset = 1'b0;
        cycle("ro_idle_hold0", 0, 1, I_BRZR, 32'h0, E_IDLE, 0, 0);
        cycle("ro_idle_hold1", 0, 1, I_BRZR, 32'h0, E_IDLE, 0, 0);
        cycle("ro_idle_go",    1, 1, I_BRZR, 32'h0, E_IDLE, 0, 0);
        cycle("ro_restart_t0", 1, 1, I_BRZR, 32'h0, E_T0,   0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule : tb_branch_step_sequencer

// File: doc/branch_step_sequencer.md
Name: branch_step_sequencer

Overview:
- Hard-wired control-step sequencer for the branch instruction class: brzr, brnz, brpl and brmi.
- Drives the datapath's existing control strobes through fetch (T0-T2) and the branch steps (T3-T6).
- Includes the condition (CON) evaluation. It replaces the hand-sequenced control used so far.
- Adds a memory wait-state handshake, run/idle gating, an illegal-opcode trap, and an optional early exit for not-taken branches.

Parameters:
- DATA_WIDTH, 32, width of bus_in and ir_in.
- OPCODE_W, 5, opcode field width, located at ir_in[DATA_WIDTH-1 -: OPCODE_W].
- BR_OPCODE, 5'b10010, opcode value that identifies the branch class.
- C2_LSB, 19, LSB of the 2-bit branch-condition field ir_in[C2_LSB+1:C2_LSB].
- ADD_OP, 5'b00011, ALU operation code driven on alu_op in T5.
- FAST_NOT_TAKEN, 1, when 1 a not-taken branch ends at T4.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- run  in  1  permits the start of a new instruction.
- mem_ready  in  1  memory read data valid; sampled in T1.
- ir_in  in  DATA_WIDTH  current IR contents.
- bus_in  in  DATA_WIDTH  current bus value; used for CON evaluation.
- PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CON_in, Yin, Cout  out  1 each  datapath strobes.
- alu_op  out  5  ALU operation select.
- con  out  1  latched branch condition.
- busy  out  1  high in any state except IDLE and RST.
- done  out  1  one-cycle pulse in the last step of an instruction.
- illegal_op  out  1  one-cycle pulse on a non-branch opcode.
- Interface facts: one clock; Reset is asynchronous and active-high.

Behaviour:
- States: RST, IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are Moore, decoded from state plus con.
- Reset assertion at any time, including mid-instruction: state=RST, con=0, all outputs 0, alu_op=0.
- RST -> IDLE on the first edge after Reset deasserts.
- IDLE: all strobes 0. If run=1, go to T0; otherwise stay.
- T0: PCout=1, MARin=1, IncPC=1, Zin=1. Next state T1.
- T1: Zlowout=1, PCin=1, Read=1, MDRin=1.
  - If mem_ready=0, stay in T1; re-loading PC from the unchanged Z is idempotent.
  - If mem_ready=1, go to T2.
  - No timeout.
- T2: MDRout=1, IRin=1. Next state T3.
- T3: opcode check.
  - If opcode != BR_OPCODE: illegal_op=1, no other strobes; next state is T0 if run=1, else IDLE.
  - Otherwise: Gra=1, Rout=1, CON_in=1. Next state T4.
  - At the T3->T4 edge, con is loaded from bus_in (the Ra value) per C2:
    - 00: con = (bus_in==0)
    - 01: con = (bus_in!=0)
    - 10: con = (bus_in[DATA_WIDTH-1]==0 && bus_in!=0)
    - 11: con = bus_in[DATA_WIDTH-1]
- T4: behaviour depends on FAST_NOT_TAKEN and con.
  - If FAST_NOT_TAKEN=1 and con=0: no strobes, done=1; next state T0 if run=1, else IDLE.
  - Otherwise: PCout=1, Yin=1. Next state T5.
- T5: Cout=1, Zin=1, alu_op=ADD_OP. alu_op is 0 in every other state. Next state T6.
- T6: Zlowout=con, PCin=con, done=1. Next state T0 if run=1, else IDLE.
- con holds its value until the next T3->T4 edge or Reset.
- run is sampled only in IDLE, the illegal path of T3, the T4 early exit, and T6. Dropping run mid-instruction does not abort the instruction.
- Strobes are never asserted in a state other than the one listed above. Exactly one state is active at a time.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - state encoding localparams
  - C2 condition codes (COND_ZR, COND_NZ, COND_PL, COND_MI)
  - ALU op constants, including ADD
  - opcode constants
- One natural sub-module: con_ff_eval (parametrised DATA_WIDTH). It holds the condition decode plus the con flip-flop, with enable CON_in and asynchronous active-high reset.

Test Plan:
- brzr taken, with FAST_NOT_TAKEN=1, mem_ready=1, run=1:
  - Stimulus: ir_in=0x92800023 (Ra=R5); bus_in=0 in T3.
  - Required: states T0..T6 in 7 cycles; con=1; Zlowout=PCin=1 in T6; done pulse in T6; alu_op=3 only in T5.
- brzr not taken, fast path:
  - Stimulus: same instruction; bus_in=0x00000005.
  - Required: con=0; done in T4; no Yin/Cout/PCin after T3; the next cycle is T0.
- brnz not taken, with FAST_NOT_TAKEN=0:
  - Stimulus: ir_in=0x92880023; bus_in=0.
  - Required: full T5/T6 sequence; PCin=0 and Zlowout=0 in T6; done in T6.
- brmi / brpl boundary checks:
  - bus_in=0x80000000 with C2=11 -> con=1.
  - bus_in=0 with C2=10 -> con=0.
  - bus_in=0x7FFFFFFF with C2=10 -> con=1.
- Memory wait and illegal opcode:
  - Stimulus: mem_ready low for 3 cycles in T1 -> T1 held 4 cycles with Read=1 throughout.
  - Stimulus: then ir_in=0x18000000 -> illegal_op pulse in T3, no Rout, return to T0.
- Reset mid-operation:
  - Stimulus: assert Reset during T5 with con=1; deassert with run=0.
  - Required: outputs 0 asynchronously (before the next edge); con=0; then RST -> IDLE and held in IDLE.
